// File: rtl/instr_mem_prog.sv
// instr_mem_prog: writable DEPTH-word instruction memory for the RV32I fetch stage.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   fetch_req/fetch_addr   fetch request with byte address from the PC
//   fetch_valid            fetch_instr/fetch_fault valid (one cycle after request)
//   fetch_instr            fetched word, NOP_WORD on fault
//   fetch_fault            misaligned or out-of-range fetch
//   busy                   clear or load in progress
//   clear_req              pulse: fill the whole array with NOP_WORD
//   prog_start/prog_base   pulse: start a byte-stream load at word prog_base
//   prog_valid/prog_byte   byte stream, little-endian within each word
//   prog_last              final byte of the stream
//   prog_ready             loader accepts a byte
//   op_done                one-cycle pulse when clear or load completes
//   prog_err               sticky: load ran past the last word
module instr_mem_prog #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_addr,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_instr,
    output logic                     fetch_fault,
    output logic                     busy,
    input  logic                     clear_req,
    input  logic                     prog_start,
    input  logic [$clog2(DEPTH)-1:0] prog_base,
    input  logic                     prog_valid,
    input  logic [7:0]               prog_byte,
    input  logic                     prog_last,
    output logic                     prog_ready,
    output logic                     op_done,
    output logic                     prog_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    // Counter is one bit wider than a word index so a load can sit at DEPTH
    // (past the end) without wrapping back onto word 0.
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_IDX  = DEPTH_CNT - 1'b1;

    logic [1:0]  state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic        op_done_q, op_done_d;
    logic        prog_err_q, prog_err_d;

    logic          fetch_valid_q;
    logic [31:0]   fetch_instr_q;
    logic          fetch_fault_q;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   load_word;
    logic          addr_fault;

    logic [31:0] mem [DEPTH];

    // Word as it would be written if the current byte closes it; lanes not
    // yet filled read as zero because asm_q is cleared per word.
    always_comb begin
        load_word = 32'h0;
        unique case (lane_q)
            2'd0: load_word = {24'h0, prog_byte};
            2'd1: load_word = {16'h0, prog_byte, asm_q[7:0]};
            2'd2: load_word = {8'h0, prog_byte, asm_q[15:0]};
            2'd3: load_word = {prog_byte, asm_q[23:0]};
            default: load_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        op_done_d  = 1'b0;
        prog_err_d = prog_err_q;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q[AW-1:0];
        mem_wdata  = NOP_WORD;

        case (state_q)
            IDLE: begin
                // Clear takes priority over a simultaneous load start.
                if (clear_req) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    prog_err_d = 1'b0;
                end else if (prog_start) begin
                    state_d    = LOAD;
                    cnt_d      = {1'b0, prog_base};
                    lane_d     = 2'd0;
                    asm_d      = 24'h0;
                    prog_err_d = 1'b0;
                end
            end

            CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = NOP_WORD;
                if (cnt_q == LAST_IDX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    op_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LOAD: begin
                if (prog_valid) begin
                    if (lane_q == 2'd3 || prog_last) begin
                        if (cnt_q < DEPTH_CNT) begin
                            mem_we    = 1'b1;
                            mem_wdata = load_word;
                            cnt_d     = cnt_q + 1'b1;
                        end else begin
                            prog_err_d = 1'b1;
                        end
                        lane_d = 2'd0;
                        asm_d  = 24'h0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        unique case (lane_q)
                            2'd0:    asm_d[7:0]   = prog_byte;
                            2'd1:    asm_d[15:8]  = prog_byte;
                            default: asm_d[23:16] = prog_byte;
                        endcase
                    end
                    if (prog_last) begin
                        state_d   = IDLE;
                        op_done_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lane_q     <= 2'd0;
            asm_q      <= 24'h0;
            op_done_q  <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            op_done_q  <= op_done_d;
            prog_err_q <= prog_err_d;
        end
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // DEPTH is a power of two, so out-of-range means any word-address bit
    // above the index width is set.
    assign addr_fault = (|fetch_addr[1:0]) | (|fetch_addr[31:AW+2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= 32'h0;
            fetch_fault_q <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_req && (state_q == IDLE);
            if (fetch_req && (state_q == IDLE)) begin
                fetch_fault_q <= addr_fault;
                fetch_instr_q <= addr_fault ? NOP_WORD : mem[fetch_addr[AW+1:2]];
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;
    assign busy        = (state_q != IDLE);
    assign prog_ready  = (state_q == LOAD);
    assign op_done     = op_done_q;
    assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// tb_instr_mem_prog: directed and randomized checks of instr_mem_prog against
// a word-array reference model.
module tb_instr_mem_prog;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        busy;
    logic        clear_req;
    logic        prog_start;
    logic [5:0]  prog_base;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_last;
    logic        prog_ready;
    logic        op_done;
    logic        prog_err;

    instr_mem_prog #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .busy        (busy),
        .clear_req   (clear_req),
        .prog_start  (prog_start),
        .prog_base   (prog_base),
        .prog_valid  (prog_valid),
        .prog_byte   (prog_byte),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .op_done     (op_done),
        .prog_err    (prog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref_mem [DEPTH];
    logic        exp_err;
    logic [7:0]  bq [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clear the array; optionally fire prog_start in the same cycle (must be ignored).
    task automatic do_clear(input bit with_start);
        int nbusy = 0;
        int ndone = 0;
        bit ended = 0;
        clear_req  = 1'b1;
        prog_start = with_start;
        prog_base  = 6'd3;
        tick;
        clear_req  = 1'b0;
        prog_start = 1'b0;
        chk("clear prog_ready", {31'h0, prog_ready}, 32'd0);
        for (int i = 0; i < 200 && !ended; i++) begin
            if (busy) nbusy++;
            if (op_done) ndone++;
            if (!busy) ended = 1;
            else tick;
        end
        chk("clear ended", {31'h0, ended}, 32'd1);
        chk("clear busy cycles", nbusy, DEPTH);
        chk("clear op_done count", ndone, 1);
        tick;
        chk("clear op_done drop", {31'h0, op_done}, 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
        exp_err = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input string tag);
        logic        f;
        logic [31:0] w;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick;
        fetch_req  = 1'b0;
        f = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
        w = f ? NOP : ref_mem[addr[7:2]];
        chk({tag, " valid"}, {31'h0, fetch_valid}, 32'd1);
        chk({tag, " fault"}, {31'h0, fetch_fault}, {31'h0, f});
        chk({tag, " instr"}, fetch_instr, w);
    endtask

    // Stream bq into the loader at word base, with random idle gaps.
    task automatic do_load(input int base, input bit fetch_mid, input string tag);
        int n     = bq.size();
        int early = 0;
        int nw;
        logic [31:0] v;
        prog_base  = 6'(base);
        prog_start = 1'b1;
        tick;
        prog_start = 1'b0;
        chk({tag, " busy"}, {31'h0, busy}, 32'd1);
        chk({tag, " prog_ready"}, {31'h0, prog_ready}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                prog_valid = 1'b0;
                tick;
                if (op_done) early++;
            end
            prog_valid = 1'b1;
            prog_byte  = bq[i];
            prog_last  = (i == n - 1);
            if (fetch_mid && i == 0) begin
                fetch_req  = 1'b1;
                fetch_addr = 32'h0;
            end
            tick;
            if (fetch_mid && i == 0) begin
                fetch_req = 1'b0;
                chk({tag, " fetch while busy"}, {31'h0, fetch_valid}, 32'd0);
            end
            if (i != n - 1 && op_done) early++;
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        chk({tag, " op_done"}, {31'h0, op_done}, 32'd1);
        chk({tag, " early op_done"}, early, 0);
        chk({tag, " busy end"}, {31'h0, busy}, 32'd0);
        exp_err = 1'b0;
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            v = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) v = v | (32'(bq[4 * w + k]) << (8 * k));
            if (base + w < DEPTH) ref_mem[base + w] = v;
            else exp_err = 1'b1;
        end
        chk({tag, " prog_err"}, {31'h0, prog_err}, {31'h0, exp_err});
    endtask

    initial begin
        int          base;
        int          idx;
        logic [31:0] a;
        rst_n      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        clear_req  = 1'b0;
        prog_start = 1'b0;
        prog_base  = 6'd0;
        prog_valid = 1'b0;
        prog_byte  = 8'h0;
        prog_last  = 1'b0;
        exp_err    = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        #2 rst_n = 1'b0;
        #3;
        chk("rst fetch_valid", {31'h0, fetch_valid}, 32'd0);
        chk("rst fetch_instr", fetch_instr, 32'h0);
        chk("rst fetch_fault", {31'h0, fetch_fault}, 32'd0);
        chk("rst busy", {31'h0, busy}, 32'd0);
        chk("rst prog_ready", {31'h0, prog_ready}, 32'd0);
        chk("rst op_done", {31'h0, op_done}, 32'd0);
        chk("rst prog_err", {31'h0, prog_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        do_clear(1'b0);
        do_fetch(32'h00, "clr f00");
        do_fetch(32'hFC, "clr ffc");
        tick;
        chk("idle no req valid", {31'h0, fetch_valid}, 32'd0);
        chk("idle hold instr", fetch_instr, NOP);

        bq = '{8'hB3, 8'h82, 8'h41, 8'h00, 8'h13, 8'h05, 8'h30, 8'h00};
        do_load(0, 1'b0, "ld0");
        do_fetch(32'h04, "ld0 f04");
        do_fetch(32'h00, "ld0 f00");
        chk("ld0 word1 literal", ref_mem[1], 32'h0030_0513);

        bq = '{8'h93, 8'h02};
        do_load(5, 1'b0, "part");
        do_fetch(32'h14, "part f14");

        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(63, 1'b0, "ovf");
        do_fetch(32'hFC, "ovf ffc");
        do_fetch(32'h00, "ovf f00");

        do_fetch(32'h02, "mis f02");
        do_fetch(32'h100, "oor f100");

        bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        do_load(20, 1'b1, "fmid");
        do_fetch(32'h50, "fmid f50");
        do_fetch(32'h54, "fmid f54");

        for (int t = 0; t < 8; t++) begin
            base = $urandom_range(0, DEPTH - 1);
            bq.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) bq.push_back(8'($urandom));
            do_load(base, 1'b0, "rnd ld");
        end
        for (int t = 0; t < 24; t++) begin
            idx = $urandom_range(0, DEPTH - 1);
            case ($urandom_range(0, 2))
                0:       a = 32'(idx * 4);
                1:       a = 32'(idx * 4 + $urandom_range(1, 3));
                default: a = $urandom;
            endcase
            do_fetch(a, "rnd f");
        end

        // Abort a load after six bytes: word 10 complete, word 11 half-built.
        bq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        prog_base  = 6'd10;
        prog_start = 1'b1;
        tick;
        prog_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1'b1;
            prog_byte  = bq[i];
            tick;
        end
        prog_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("abort busy", {31'h0, busy}, 32'd0);
        chk("abort op_done", {31'h0, op_done}, 32'd0);
        chk("abort prog_ready", {31'h0, prog_ready}, 32'd0);
        ref_mem[10] = 32'hC3C2_C1C0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("abort op_done later", {31'h0, op_done}, 32'd0);
        do_fetch(32'h28, "abort f28");
        do_fetch(32'h2C, "abort f2c");

        do_clear(1'b1);
        do_fetch(32'h28, "clr2 f28");
        do_fetch(32'h0C, "clr2 f0c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
